// File: rtl/delta_encoder.sv
// ---------------------------------------------------------------------------
// delta_encoder
//
// Purpose: iterative re-encoder that turns an OUT_W-bit unsigned value into
// a (mantissa, delta) pair with value ~= out_mant << out_shift. The value is
// shifted right one bit per clock until it fits in BIN_W bits. The result
// uses the smallest shift that fits. The discarded low bits are reported
// through out_inexact. Values that still do not fit after MAX_SHIFT shifts
// saturate to an all-ones mantissa with out_overflow set. Only one operand
// is in flight at a time.
//
// Optional feature: define DELTA_ENCODER_ROUND_EN to round half up at the
// fit step instead of truncating. Without the macro the encoder truncates.
//
// Ports:
//   clock        in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   in_valid     in   in_val is valid
//   in_ready     out  encoder idle, can accept an operand
//   in_val       in   [OUT_W-1:0] unsigned value to encode
//   out_valid    out  encoded result valid
//   out_ready    in   consumer accepts result
//   out_mant     out  [BIN_W-1:0] mantissa
//   out_shift    out  [DELTA_W-1:0] left-shift amount
//   out_inexact  out  nonzero bits were discarded
//   out_overflow out  value not representable, result saturated
// ---------------------------------------------------------------------------
module delta_encoder #(
    parameter int BIN_W   = 8,
    parameter int DELTA_W = 3,
    parameter int OUT_W   = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OUT_W-1:0]   in_val,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BIN_W-1:0]   out_mant,
    output logic [DELTA_W-1:0] out_shift,
    output logic               out_inexact,
    output logic               out_overflow
);

    localparam logic [DELTA_W-1:0] MAX_SHIFT = '1;
    localparam logic [BIN_W-1:0]   MANT_ONES = '1;
    localparam logic [BIN_W-1:0]   MANT_HALF = {1'b1, {(BIN_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Round half up: the extra top bit is the carry out of the mantissa.
    function automatic logic [BIN_W:0] round_half_up(input logic [BIN_W-1:0] mant,
                                                     input logic             guard);
        return {1'b0, mant} + {{BIN_W{1'b0}}, guard};
    endfunction

    // Saturated result used whenever the value cannot be represented.
    function automatic logic [BIN_W-1:0] sat_mant();
        return MANT_ONES;
    endfunction

    state_t               state_q, state_d;
    logic [OUT_W-1:0]     work_q, work_d;
    logic [DELTA_W-1:0]   count_q, count_d;
    logic                 sticky_q, sticky_d;
    logic                 guard_q, guard_d;
    logic [BIN_W-1:0]     mant_q, mant_d;
    logic [DELTA_W-1:0]   shift_q, shift_d;
    logic                 inexact_q, inexact_d;
    logic                 overflow_q, overflow_d;
    logic                 fit;
`ifdef DELTA_ENCODER_ROUND_EN
    logic [BIN_W:0]       rnd_sum;
`endif

    // The value fits once nothing remains above the mantissa field.
    assign fit = (work_q[OUT_W-1:BIN_W] == '0);

    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        count_d    = count_q;
        sticky_d   = sticky_q;
        guard_d    = guard_q;
        mant_d     = mant_q;
        shift_d    = shift_q;
        inexact_d  = inexact_q;
        overflow_d = overflow_q;
`ifdef DELTA_ENCODER_ROUND_EN
        rnd_sum    = '0;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d   = in_val;
                    count_d  = '0;
                    sticky_d = 1'b0;
                    guard_d  = 1'b0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (fit) begin
                    // sticky holds every discarded bit except the last one,
                    // which sits in guard.
                    inexact_d  = sticky_q | guard_q;
                    overflow_d = 1'b0;
                    shift_d    = count_q;
`ifdef DELTA_ENCODER_ROUND_EN
                    rnd_sum = round_half_up(work_q[BIN_W-1:0], guard_q);
                    if (!rnd_sum[BIN_W]) begin
                        mant_d = rnd_sum[BIN_W-1:0];
                    end else if (count_q != MAX_SHIFT) begin
                        // Carry out means the mantissa became 2^BIN_W,
                        // which re-encodes as half scale at one more shift.
                        mant_d  = MANT_HALF;
                        shift_d = count_q + DELTA_W'(1);
                    end else begin
                        mant_d     = sat_mant();
                        shift_d    = MAX_SHIFT;
                        overflow_d = 1'b1;
                    end
`else
                    mant_d = work_q[BIN_W-1:0];
`endif
                    state_d = DONE;
                end else if (count_q == MAX_SHIFT) begin
                    mant_d     = sat_mant();
                    shift_d    = MAX_SHIFT;
                    inexact_d  = 1'b1;
                    overflow_d = 1'b1;
                    state_d    = DONE;
                end else begin
                    sticky_d = sticky_q | guard_q;
                    guard_d  = work_q[0];
                    work_d   = work_q >> 1;
                    count_d  = count_q + DELTA_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            work_q     <= '0;
            count_q    <= '0;
            sticky_q   <= 1'b0;
            guard_q    <= 1'b0;
            mant_q     <= '0;
            shift_q    <= '0;
            inexact_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            count_q    <= count_d;
            sticky_q   <= sticky_d;
            guard_q    <= guard_d;
            mant_q     <= mant_d;
            shift_q    <= shift_d;
            inexact_q  <= inexact_d;
            overflow_q <= overflow_d;
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign out_valid    = (state_q == DONE);
    assign out_mant     = mant_q;
    assign out_shift    = shift_q;
    assign out_inexact  = inexact_q;
    assign out_overflow = overflow_q;

endmodule

// File: tb/tb_delta_encoder.sv
// ---------------------------------------------------------------------------
// tb_delta_encoder
//
// Scoreboard bench for delta_encoder. The driver pushes the expected result
// for each accepted operand, computed from the encoding rules with plain
// arithmetic. A separate monitor pops and compares whenever out_valid rises.
// The monitor also checks latency, stability under backpressure and the
// handshake release. Directed cases, a mid-operation reset and random
// operands are applied. Define DELTA_ENCODER_ROUND_EN for both files together.
// ---------------------------------------------------------------------------
module tb_delta_encoder;

    localparam int BIN_W     = 8;
    localparam int DELTA_W   = 3;
    localparam int OUT_W     = 16;
    localparam int MAX_SHIFT = (1 << DELTA_W) - 1;
`ifdef DELTA_ENCODER_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic               clock;
    logic               reset_n;
    logic               in_valid;
    logic               in_ready;
    logic [OUT_W-1:0]   in_val;
    logic               out_valid;
    logic               out_ready;
    logic [BIN_W-1:0]   out_mant;
    logic [DELTA_W-1:0] out_shift;
    logic               out_inexact;
    logic               out_overflow;

    delta_encoder #(.BIN_W(BIN_W), .DELTA_W(DELTA_W), .OUT_W(OUT_W)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_val      (in_val),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_mant    (out_mant),
        .out_shift   (out_shift),
        .out_inexact (out_inexact),
        .out_overflow(out_overflow)
    );

    typedef struct {
        int unsigned val;
        int          mant;
        int          shift;
        int          inex;
        int          ovf;
        int          lat;
        int          hold;
        int          acc;
    } exp_t;

    exp_t queue_exp[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic cmp(input string nm, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference: smallest shift s with (v >> s) < 2^BIN_W, then optional
    // round half up, with saturation when no legal shift exists.
    function automatic exp_t model(input int unsigned v, input int hold);
        exp_t        e;
        int          s;
        int unsigned m;
        s = 0;
        while (s <= MAX_SHIFT && (v >> s) >= (1 << BIN_W)) s++;
        e.val  = v;
        e.hold = hold;
        e.acc  = 0;
        e.ovf  = 0;
        if (s > MAX_SHIFT) begin
            e.lat = MAX_SHIFT + 1;
            e.mant = (1 << BIN_W) - 1;
            e.shift = MAX_SHIFT;
            e.inex = 1;
            e.ovf = 1;
        end else begin
            e.lat  = s + 1;
            e.inex = ((v & ((1 << s) - 1)) != 0) ? 1 : 0;
            m = v >> s;
            if (ROUND && s > 0) m = m + ((v >> (s - 1)) & 1);
            if (m == (1 << BIN_W)) begin
                if (s == MAX_SHIFT) begin
                    e.mant = (1 << BIN_W) - 1;
                    e.shift = MAX_SHIFT;
                    e.ovf = 1;
                end else begin
                    e.mant = 1 << (BIN_W - 1);
                    e.shift = s + 1;
                end
            end else begin
                e.mant = int'(m);
                e.shift = s;
            end
        end
        return e;
    endfunction

    // Present one operand; when push is set the expected result is queued.
    task automatic send(input int unsigned v, input int hold, input bit push);
        exp_t e;
        int   n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) begin
            cmp("accept_timeout", 0, 1);
            return;
        end
        in_valid = 1'b1;
        in_val   = v[OUT_W-1:0];
        if (push) begin
            e = model(v, hold);
            e.acc = cyc + 1;
            queue_exp.push_back(e);
        end
        @(negedge clock);
        in_valid = 1'b0;
        in_val   = OUT_W'($urandom);
    endtask

    // ---------------- monitor / scoreboard ----------------
    exp_t             cur;
    bit               seen    = 0;
    bit               prev_hs = 0;
    int               hold_left = 0;
    logic [BIN_W-1:0] h_mant;
    logic [DELTA_W-1:0] h_shift;
    logic             h_inex, h_ovf;

    initial out_ready = 1'b0;

    always @(negedge clock) begin
        if (!reset_n) begin
            seen = 0;
            prev_hs = 0;
            hold_left = 0;
            out_ready = 1'b0;
        end else begin
            if (prev_hs) begin
                cmp("valid_drop", int'(out_valid), 0);
                cmp("ready_after", int'(in_ready), 1);
                prev_hs = 0;
            end else if (out_valid) begin
                cmp("in_ready_busy", int'(in_ready), 0);
                if (!seen) begin
                    if (queue_exp.size() == 0) begin
                        cmp("unexpected_valid", 1, 0);
                    end else begin
                        cur = queue_exp.pop_front();
                        cmp($sformatf("mant[%0h]", cur.val), int'(out_mant), cur.mant);
                        cmp($sformatf("shift[%0h]", cur.val), int'(out_shift), cur.shift);
                        cmp($sformatf("inexact[%0h]", cur.val), int'(out_inexact), cur.inex);
                        cmp($sformatf("overflow[%0h]", cur.val), int'(out_overflow), cur.ovf);
                        cmp($sformatf("latency[%0h]", cur.val), cyc - cur.acc, cur.lat);
                        hold_left = cur.hold;
                    end
                    seen = 1;
                    h_mant = out_mant;
                    h_shift = out_shift;
                    h_inex = out_inexact;
                    h_ovf = out_overflow;
                end else begin
                    cmp("hold_mant", int'(out_mant), int'(h_mant));
                    cmp("hold_shift", int'(out_shift), int'(h_shift));
                    cmp("hold_flags", int'({out_inexact, out_overflow}), int'({h_inex, h_ovf}));
                end
                if (hold_left > 0) begin
                    out_ready = 1'b0;
                    hold_left--;
                end else begin
                    out_ready = 1'b1;
                    prev_hs = 1;
                    seen = 0;
                end
            end else begin
                out_ready = 1'($urandom);
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while ((queue_exp.size() != 0 || seen || out_valid || prev_hs) && n < 2000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 2000) cmp("drain_timeout", queue_exp.size(), 0);
    endtask

    task automatic check_cleared(input string nm);
        cmp({nm, "_valid"}, int'(out_valid), 0);
        cmp({nm, "_ready"}, int'(in_ready), 1);
        cmp({nm, "_mant"}, int'(out_mant), 0);
        cmp({nm, "_shift"}, int'(out_shift), 0);
        cmp({nm, "_flags"}, int'({out_inexact, out_overflow}), 0);
    endtask

    initial begin
        int unsigned v;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_val   = '0;
        #3;
        check_cleared("reset");
        repeat (2) @(negedge clock);
        #2 reset_n = 1'b1;
        @(negedge clock);

        // Directed cases, including a 3-cycle backpressure hold.
        send(32'h005A, 0, 1);
        send(32'h0B40, 3, 1);
        send(32'h01FF, 0, 1);
        send(32'h8000, 2, 1);
        send(32'h7FFF, 0, 1);
        send(32'h0000, 1, 1);
        send(32'hFFFF, 0, 1);
        send(32'h00FF, 0, 1);
        send(32'h0100, 0, 1);
        drain();

        // Reset in the middle of shifting 0x7FFF: result must never appear.
        send(32'h7FFF, 0, 0);
        repeat (2) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check_cleared("midreset");
        @(negedge clock);
        #2 reset_n = 1'b1;
        repeat (12) @(negedge clock);
        cmp("no_stale_valid", int'(out_valid), 0);
        send(32'h0001, 0, 1);
        drain();

        // Random operands across all magnitudes with random backpressure.
        for (int i = 0; i < 200; i++) begin
            v = $urandom & ((32'd1 << $urandom_range(0, OUT_W)) - 1);
            send(v, $urandom_range(0, 3), 1);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
